// File: rtl/utri_operand_sequencer.sv
// Generic synchronous FIFO with registered storage; the head entry drives the outputs.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_vld,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop_rdy,
    output logic                         head_vld,
    output logic [W-1:0]                 head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign head_vld = (count != '0);
    assign head_dat = mem[rd_ptr];
    assign do_pop   = pop_rdy && head_vld;
    assign do_push  = push_vld && ((count != CW'(DEPTH)) || do_pop);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < DEPTH; n++) mem[n] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end
endmodule

// Streams non-zero operand pairs of an upper-triangular A*B with (i,j) tags and first/last marks.
// Latency: first beat valid 2 cycles after the first read (1 RAM cycle, 1 FIFO cycle).
// Backpressure: reads are credited against a 2-entry output FIFO; ready_in low stalls the stream.
module utri_operand_sequencer #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int AW = (N*(N+1)/2 > 1) ? $clog2(N*(N+1)/2) : 1,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          a_rd_en,
    output logic [AW-1:0] a_rd_addr,
    input  logic [DW-1:0] a_rd_data,
    output logic          b_rd_en,
    output logic [AW-1:0] b_rd_addr,
    input  logic [DW-1:0] b_rd_data,
    output logic          valid_out,
    input  logic          ready_in,
    output logic [DW-1:0] data_a,
    output logic [DW-1:0] data_b,
    output logic          first,
    output logic          last,
    output logic [IW-1:0] out_row,
    output logic [IW-1:0] out_col
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic          first;
        logic          last;
        logic [IW-1:0] row;
        logic [IW-1:0] col;
    } tag_t;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        tag_t          tag;
    } beat_t;

    state_t        state, state_nxt;
    logic [IW-1:0] i_idx, j_idx, k_idx;
    logic [AW-1:0] addr_a, addr_b, row_base;
    logic          issue_vld, last_issue, credit_ok, pop;
    logic          rd_inflight, done_nxt, done_q;
    tag_t          tag_nxt, tag_q;
    beat_t         push_beat, head;
    logic          head_vld;
    logic [1:0]    fifo_cnt;

    assign pop        = head_vld && ready_in;
    // A pop in this cycle frees a slot in time for the read issued now.
    assign credit_ok  = ({1'b0, fifo_cnt} + {2'b0, rd_inflight}) < (3'd2 + {2'b0, pop});
    assign last_issue = (i_idx == IW'(N-1)) && (j_idx == IW'(N-1)) && (k_idx == IW'(N-1));

    always_comb begin
        state_nxt = state;
        issue_vld = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = ISSUE;
            ISSUE: if (credit_ok) begin
                issue_vld = 1'b1;
                if (last_issue) state_nxt = DRAIN;
            end
            DRAIN: if (!rd_inflight && (fifo_cnt == 2'd0 || (fifo_cnt == 2'd1 && pop))) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            done_q      <= 1'b0;
            rd_inflight <= 1'b0;
            tag_q       <= '0;
        end else begin
            state       <= state_nxt;
            done_q      <= done_nxt;
            rd_inflight <= issue_vld;
            if (issue_vld) tag_q <= tag_nxt;
        end
    end

    // Incremental packed-address walk: k inner, then j, then i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_idx    <= '0;
            j_idx    <= '0;
            k_idx    <= '0;
            addr_a   <= '0;
            addr_b   <= '0;
            row_base <= '0;
        end else if (issue_vld) begin
            if (k_idx != j_idx) begin
                k_idx  <= k_idx + IW'(1);
                addr_a <= addr_a + AW'(1);
                addr_b <= addr_b + AW'(N-1) - AW'(k_idx);
            end else if (j_idx != IW'(N-1)) begin
                j_idx  <= j_idx + IW'(1);
                k_idx  <= i_idx;
                addr_a <= row_base;
                addr_b <= row_base + AW'(j_idx) + AW'(1) - AW'(i_idx);
            end else if (i_idx != IW'(N-1)) begin
                i_idx    <= i_idx + IW'(1);
                j_idx    <= i_idx + IW'(1);
                k_idx    <= i_idx + IW'(1);
                row_base <= row_base + AW'(N) - AW'(i_idx);
                addr_a   <= row_base + AW'(N) - AW'(i_idx);
                addr_b   <= row_base + AW'(N) - AW'(i_idx);
            end else begin
                i_idx    <= '0;
                j_idx    <= '0;
                k_idx    <= '0;
                addr_a   <= '0;
                addr_b   <= '0;
                row_base <= '0;
            end
        end
    end

    assign tag_nxt.first = (k_idx == i_idx);
    assign tag_nxt.last  = (k_idx == j_idx);
    assign tag_nxt.row   = i_idx;
    assign tag_nxt.col   = j_idx;

    assign push_beat.a   = a_rd_data;
    assign push_beat.b   = b_rd_data;
    assign push_beat.tag = tag_q;

    sync_fifo #(
        .W     ($bits(beat_t)),
        .DEPTH (2)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (rd_inflight),
        .push_dat (push_beat),
        .pop_rdy  (ready_in),
        .head_vld (head_vld),
        .head_dat (head),
        .count    (fifo_cnt)
    );

    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign a_rd_en   = issue_vld;
    assign b_rd_en   = issue_vld;
    assign a_rd_addr = addr_a;
    assign b_rd_addr = addr_b;
    assign valid_out = head_vld;
    assign data_a    = head.a;
    assign data_b    = head.b;
    assign first     = head.tag.first;
    assign last      = head.tag.last;
    assign out_row   = head.tag.row;
    assign out_col   = head.tag.col;
endmodule

// File: tb/tb_utri_operand_sequencer.sv
// Directed bench for utri_operand_sequencer: N=4 table-driven passes plus N=3 and N=1 instances.
module tb_utri_operand_sequencer;
    localparam int DW = 32;

    typedef struct packed {
        logic [1:0]    row;
        logic [1:0]    col;
        logic          first;
        logic          last;
        logic [DW-1:0] da;
        logic [DW-1:0] db;
    } obs_t;

    typedef struct packed { int i; int j; int k; int aa; int ab; } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // N=4
    logic          start4, busy4, done4, a_en4, b_en4, vld4, rdy4, first4, last4;
    logic [3:0]    a_addr4, b_addr4;
    logic [DW-1:0] a_dat4, b_dat4, da4, db4;
    logic [1:0]    row4, col4;
    // N=3
    logic          start3, busy3, done3, a_en3, b_en3, vld3, rdy3, first3, last3;
    logic [2:0]    a_addr3, b_addr3;
    logic [DW-1:0] a_dat3, b_dat3, da3, db3;
    logic [1:0]    row3, col3;
    // N=1
    logic          start1, busy1, done1, a_en1, b_en1, vld1, rdy1, first1, last1;
    logic [0:0]    a_addr1, b_addr1;
    logic [DW-1:0] a_dat1, b_dat1, da1, db1;
    logic [0:0]    row1, col1;

    utri_operand_sequencer #(.N(4), .DW(DW)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4),
        .a_rd_en(a_en4), .a_rd_addr(a_addr4), .a_rd_data(a_dat4),
        .b_rd_en(b_en4), .b_rd_addr(b_addr4), .b_rd_data(b_dat4),
        .valid_out(vld4), .ready_in(rdy4), .data_a(da4), .data_b(db4),
        .first(first4), .last(last4), .out_row(row4), .out_col(col4));

    utri_operand_sequencer #(.N(3), .DW(DW)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
        .a_rd_en(a_en3), .a_rd_addr(a_addr3), .a_rd_data(a_dat3),
        .b_rd_en(b_en3), .b_rd_addr(b_addr3), .b_rd_data(b_dat3),
        .valid_out(vld3), .ready_in(rdy3), .data_a(da3), .data_b(db3),
        .first(first3), .last(last3), .out_row(row3), .out_col(col3));

    utri_operand_sequencer #(.N(1), .DW(DW)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .a_rd_en(a_en1), .a_rd_addr(a_addr1), .a_rd_data(a_dat1),
        .b_rd_en(b_en1), .b_rd_addr(b_addr1), .b_rd_data(b_dat1),
        .valid_out(vld1), .ready_in(rdy1), .data_a(da1), .data_b(db1),
        .first(first1), .last(last1), .out_row(row1), .out_col(col1));

    logic [DW-1:0] mem_a4 [16];
    logic [DW-1:0] mem_b4 [16];

    always @(posedge clk) begin
        if (a_en4) a_dat4 <= mem_a4[a_addr4];
        if (b_en4) b_dat4 <= mem_b4[b_addr4];
        if (a_en3) a_dat3 <= 32'h300 + 32'(a_addr3);
        if (b_en3) b_dat3 <= 32'h400 + 32'(b_addr3);
        if (a_en1) a_dat1 <= 32'h500 + 32'(a_addr1);
        if (b_en1) b_dat1 <= 32'h600 + 32'(b_addr1);
    end

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t tbl [20];

    obs_t       beats[$];
    int         beat_cyc[$];
    logic [7:0] rd_addrs[$];
    int         cyc = 0;
    int         done_cnt, done_cyc, first_rd_cyc, first_vld_cyc, max_occ;
    logic       busy_at_done;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setv(input int n, input int i, input int j, input int k, input int aa, input int ab);
        tbl[n] = '{i, j, k, aa, ab};
    endtask

    task automatic load_ramp();
        for (int n = 0; n < 16; n++) begin
            mem_a4[n] = 32'h100 + 32'(n);
            mem_b4[n] = 32'h200 + 32'(n);
        end
    endtask

    task automatic load_identity();
        for (int n = 0; n < 16; n++) begin
            mem_a4[n] = (n == 0 || n == 4 || n == 7 || n == 9) ? 32'd1 : 32'd0;
            mem_b4[n] = mem_a4[n];
        end
    endtask

    function automatic obs_t exp_beat(input int n);
        obs_t e;
        e.row   = 2'(tbl[n].i);
        e.col   = 2'(tbl[n].j);
        e.first = (tbl[n].k == tbl[n].i);
        e.last  = (tbl[n].k == tbl[n].j);
        e.da    = mem_a4[tbl[n].aa];
        e.db    = mem_b4[tbl[n].ab];
        return e;
    endfunction

    // Observer for the N=4 instance, sampling on the falling edge.
    initial begin
        obs_t cur;
        obs_t held;
        logic held_vld;
        held_vld = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            cur = '{row: row4, col: col4, first: first4, last: last4, da: da4, db: db4};
            if (held_vld && rst_n) check("stall_hold", {vld4, cur}, {1'b1, held});
            held_vld = 1'b0;
            if (a_en4) begin
                rd_addrs.push_back({a_addr4, b_addr4});
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            if (vld4 && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (vld4 && !rdy4) begin
                held     = cur;
                held_vld = 1'b1;
            end
            if (vld4 && rdy4) begin
                beats.push_back(cur);
                beat_cyc.push_back(cyc);
            end
            if (done4) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy4;
            end
            if (int'(u4.u_fifo.count) > max_occ) max_occ = int'(u4.u_fifo.count);
        end
    end

    task automatic clear_obs();
        beats.delete();
        beat_cyc.delete();
        rd_addrs.delete();
        done_cnt      = 0;
        done_cyc      = -1;
        first_rd_cyc  = -1;
        first_vld_cyc = -1;
        max_occ       = 0;
        busy_at_done  = 1'b1;
    endtask

    task automatic run_pass(input bit rnd, input bit extra_start);
        bit xs_done;
        int t;
        xs_done = 1'b0;
        t = 0;
        clear_obs();
        @(posedge clk); #1;
        start4 = 1'b1;
        rdy4   = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        while (done_cnt == 0 && t < 400) begin
            rdy4 = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (extra_start && !xs_done && beats.size() == 5) begin
                start4  = 1'b1;
                xs_done = 1'b1;
            end else begin
                start4 = 1'b0;
            end
            @(posedge clk); #1;
            t++;
        end
        check("pass_timeout", t >= 400, 0);
        start4 = 1'b0;
        rdy4   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic verify_pass(input string nm, input bit timing);
        int nb;
        nb = (beats.size() < 20) ? beats.size() : 20;
        check({nm, "_count"}, beats.size(), 20);
        check({nm, "_reads"}, rd_addrs.size(), 20);
        check({nm, "_done_cnt"}, done_cnt, 1);
        check({nm, "_busy_at_done"}, busy_at_done, 0);
        check({nm, "_done_cyc"}, done_cyc, (beat_cyc.size() > 0) ? beat_cyc[beat_cyc.size()-1] + 1 : -2);
        check({nm, "_occ"}, max_occ > 2, 0);
        for (int n = 0; n < nb; n++)
            check($sformatf("%s_beat%0d", nm, n), beats[n], exp_beat(n));
        for (int n = 0; n < rd_addrs.size() && n < 20; n++)
            check($sformatf("%s_addr%0d", nm, n), rd_addrs[n], {4'(tbl[n].aa), 4'(tbl[n].ab)});
        if (timing && nb == 20) begin
            check({nm, "_back2back"}, beat_cyc[19] - beat_cyc[0], 19);
            check({nm, "_latency"}, first_vld_cyc - first_rd_cyc, 2);
        end
    endtask

    initial begin
        int          t, n, d, bc, dc, nrd;
        logic [63:0] b2;
        logic [69:0] bl;
        logic [3:0]  tg1;
        logic [63:0] dat1;
        logic [1:0]  ra1;

        //       n  i  j  k  addrA addrB
        setv( 0, 0, 0, 0, 0, 0); setv( 1, 0, 1, 0, 0, 1); setv( 2, 0, 1, 1, 1, 4);
        setv( 3, 0, 2, 0, 0, 2); setv( 4, 0, 2, 1, 1, 5); setv( 5, 0, 2, 2, 2, 7);
        setv( 6, 0, 3, 0, 0, 3); setv( 7, 0, 3, 1, 1, 6); setv( 8, 0, 3, 2, 2, 8);
        setv( 9, 0, 3, 3, 3, 9); setv(10, 1, 1, 1, 4, 4); setv(11, 1, 2, 1, 4, 5);
        setv(12, 1, 2, 2, 5, 7); setv(13, 1, 3, 1, 4, 6); setv(14, 1, 3, 2, 5, 8);
        setv(15, 1, 3, 3, 6, 9); setv(16, 2, 2, 2, 7, 7); setv(17, 2, 3, 2, 7, 8);
        setv(18, 2, 3, 3, 8, 9); setv(19, 3, 3, 3, 9, 9);

        rst_n  = 1'b0;
        start4 = 1'b0; start3 = 1'b0; start1 = 1'b0;
        rdy4   = 1'b1; rdy3   = 1'b1; rdy1   = 1'b1;
        load_ramp();
        clear_obs();
        repeat (3) @(negedge clk);
        check("rst_ctrl", {busy4, done4, a_en4, b_en4, vld4}, 0);
        check("rst_addr", {a_addr4, b_addr4}, 0);
        check("rst_beat", {da4, db4, first4, last4, row4, col4}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Full-throughput pass
        run_pass(1'b0, 1'b0);
        verify_pass("seq", 1'b1);

        // Identity operands: product is 1 only on i==j==k
        load_identity();
        run_pass(1'b0, 1'b0);
        verify_pass("ident", 1'b0);
        for (int m = 0; m < beats.size() && m < 20; m++)
            check($sformatf("ident_prod%0d", m), beats[m].da * beats[m].db,
                  (tbl[m].i == tbl[m].j && tbl[m].j == tbl[m].k) ? 1 : 0);

        // Random backpressure
        load_ramp();
        run_pass(1'b1, 1'b0);
        verify_pass("rand", 1'b0);

        // Start pulse while busy is ignored
        run_pass(1'b0, 1'b1);
        verify_pass("xstart", 1'b0);

        // Reset in the middle of a pass
        clear_obs();
        @(posedge clk); #1;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        t = 0;
        while (beats.size() < 7 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("rst_wait", t >= 200, 0);
        rst_n = 1'b0;
        #1;
        check("rst_async", {vld4, busy4, a_en4}, 0);
        repeat (2) @(negedge clk);
        check("rst_hold", {vld4, busy4, a_en4, done4}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_obs();
        repeat (3) @(negedge clk);
        check("rst_no_stale", {vld4, busy4, done4, 8'(beats.size()), 8'(done_cnt)}, 0);
        run_pass(1'b0, 1'b0);
        verify_pass("after_rst", 1'b1);

        // N=3: ten beats
        n = 0; d = 0; bc = -1; dc = -1; b2 = '0; bl = '0;
        @(posedge clk); #1;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (vld3 && rdy3) begin
                n++;
                bc = c;
                if (n == 2) b2 = {da3, db3};
                bl = {row3, col3, first3, last3, da3, db3};
            end
            if (done3) begin
                d++;
                dc = c;
            end
        end
        check("n3_beats", n, 10);
        check("n3_done", d, 1);
        check("n3_done_cyc", dc, bc + 1);
        check("n3_beat2", b2, {32'h300, 32'h401});
        check("n3_last", bl, {2'd2, 2'd2, 1'b1, 1'b1, 32'h305, 32'h405});

        // N=1: a single beat
        n = 0; d = 0; bc = -1; dc = -1; nrd = 0; tg1 = '0; dat1 = '0; ra1 = 2'b11;
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (a_en1) begin
                nrd++;
                ra1 = {a_addr1, b_addr1};
            end
            if (vld1 && rdy1) begin
                n++;
                bc   = c;
                tg1  = {first1, last1, row1, col1};
                dat1 = {da1, db1};
            end
            if (done1) begin
                d++;
                dc = c;
            end
        end
        check("n1_beats", n, 1);
        check("n1_tag", tg1, 4'b1100);
        check("n1_data", dat1, {32'h500, 32'h600});
        check("n1_reads", {8'(nrd), ra1}, {8'd1, 2'b00});
        check("n1_done", d, 1);
        check("n1_done_cyc", dc, bc + 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
